// File: rtl/adc_sample_sequencer.sv
// ADC scan sequencer: walks the channels selected in the mask, settles the
// analog mux, fires a conversion, collects each result, and raises an
// end-of-sweep interrupt.
module adc_sample_sequencer #(
  parameter int unsigned NUM_CH         = 8,
  parameter int unsigned RES_W          = 12,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic                      cfg_enable,
  input  logic [NUM_CH-1:0]         cfg_ch_mask,
  input  logic [15:0]               cfg_period,
  input  logic                      sw_trigger,
  input  logic                      err_clr,
  output logic [$clog2(NUM_CH)-1:0] adc_amux,
  output logic                      adc_start,
  input  logic                      adc_done,
  input  logic [RES_W-1:0]          adc_data,
  output logic                      res_valid,
  output logic [$clog2(NUM_CH)-1:0] res_ch,
  output logic [RES_W-1:0]          res_data,
  output logic                      seq_busy,
  output logic                      seq_done_irq,
  output logic                      timeout_err,
  output logic                      overrun_err
);
  localparam int unsigned CH_W    = $clog2(NUM_CH);
  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, SELECT, SETTLE, START, WAIT_DONE, STORE} state_t;

  state_t            state;
  logic [NUM_CH-1:0] work_mask;
  logic [NUM_CH-1:0] mask_left;
  logic [CH_W-1:0]   low_ch;
  logic [CNT_W-1:0]  cnt;
  logic              pending;

  logic              en_q;
  logic [15:0]       period_q;
  logic [15:0]       per_cnt;
  logic              per_run;
  logic              per_load;
  logic              tick;
  logic              trig;
  logic              timeout_hit;
  logic              overrun_hit;

  // Period timer restarts from a fresh load on enable rise or period change.
  assign per_run  = cfg_enable && (cfg_period != 16'd0);
  assign per_load = !en_q || (cfg_period != period_q);
  assign tick     = per_run && !per_load && (per_cnt == 16'd0);
  assign trig     = cfg_enable && (sw_trigger || tick);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      en_q     <= 1'b0;
      period_q <= '0;
      per_cnt  <= '0;
    end else begin
      en_q     <= cfg_enable;
      period_q <= cfg_period;
      if (!per_run)
        per_cnt <= '0;
      else if (per_load || (per_cnt == 16'd0))
        per_cnt <= cfg_period - 16'd1;
      else
        per_cnt <= per_cnt - 16'd1;
    end
  end

  always_comb begin
    low_ch = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      if (work_mask[NUM_CH-1-i]) low_ch = CH_W'(NUM_CH-1-i);
  end

  assign mask_left   = work_mask & ~(NUM_CH'(1) << adc_amux);
  assign timeout_hit = cfg_enable && (state == WAIT_DONE) && !adc_done &&
                       (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign overrun_hit = trig && (state != IDLE) && pending;
  assign seq_busy    = (state != IDLE);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state        <= IDLE;
      work_mask    <= '0;
      cnt          <= '0;
      pending      <= 1'b0;
      adc_amux     <= '0;
      adc_start    <= 1'b0;
      res_valid    <= 1'b0;
      res_ch       <= '0;
      res_data     <= '0;
      seq_done_irq <= 1'b0;
      timeout_err  <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      adc_start    <= 1'b0;
      res_valid    <= 1'b0;
      seq_done_irq <= 1'b0;
      // Set beats clear when both land in the same cycle.
      timeout_err  <= (timeout_err && !err_clr) || timeout_hit;
      overrun_err  <= (overrun_err && !err_clr) || overrun_hit;

      if (!cfg_enable) begin
        state   <= IDLE;
        pending <= 1'b0;
      end else begin
        if ((state != IDLE) && trig) pending <= 1'b1;
        // seq_done_irq is registered on entry to SELECT whenever nothing is left to convert.
        unique case (state)
          IDLE: begin
            if (trig || pending) begin
              work_mask    <= cfg_ch_mask;
              pending      <= 1'b0;
              seq_done_irq <= (cfg_ch_mask == '0);
              state        <= SELECT;
            end
          end
          SELECT: begin
            if (work_mask == '0) begin
              state <= IDLE;
            end else begin
              adc_amux <= low_ch;
              cnt      <= '0;
              state    <= SETTLE;
            end
          end
          SETTLE: begin
            if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
              adc_start <= 1'b1;
              state     <= START;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          START: begin
            cnt   <= '0;
            state <= WAIT_DONE;
          end
          WAIT_DONE: begin
            if (adc_done) begin
              res_data  <= adc_data;
              res_ch    <= adc_amux;
              res_valid <= 1'b1;
              state     <= STORE;
            end else if (timeout_hit) begin
              work_mask    <= mask_left;
              seq_done_irq <= (mask_left == '0);
              state        <= SELECT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STORE: begin
            work_mask    <= mask_left;
            seq_done_irq <= (mask_left == '0);
            state        <= SELECT;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_adc_sample_sequencer.sv
module tb_adc_sample_sequencer;
  localparam int SETTLE = 16;
  localparam int TMO    = 1023;
  localparam int LAT    = 5;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cfg_enable;
  logic [7:0]  cfg_ch_mask;
  logic [15:0] cfg_period;
  logic        sw_trigger;
  logic        err_clr;
  logic [2:0]  adc_amux;
  logic        adc_start;
  logic        adc_done;
  logic [11:0] adc_data;
  logic        res_valid;
  logic [2:0]  res_ch;
  logic [11:0] res_data;
  logic        seq_busy;
  logic        seq_done_irq;
  logic        timeout_err;
  logic        overrun_err;

  adc_sample_sequencer #(
    .NUM_CH(8), .RES_W(12), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .cfg_enable(cfg_enable),
    .cfg_ch_mask(cfg_ch_mask), .cfg_period(cfg_period),
    .sw_trigger(sw_trigger), .err_clr(err_clr),
    .adc_amux(adc_amux), .adc_start(adc_start), .adc_done(adc_done),
    .adc_data(adc_data), .res_valid(res_valid), .res_ch(res_ch),
    .res_data(res_data), .seq_busy(seq_busy), .seq_done_irq(seq_done_irq),
    .timeout_err(timeout_err), .overrun_err(overrun_err)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  // Expected event schedule keyed by cycle number.
  bit         exp_start[int];
  bit         exp_irq[int];
  bit         exp_busy[int];
  int         exp_res[int];
  logic [2:0] exp_amux[int];

  logic [7:0] dead_mask = 8'h00;
  int         resp_due  = -1;
  logic [2:0] resp_ch   = 3'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
  endtask

  // Sweep triggered in IDLE at cycle n: SELECT at n+1, each channel settles
  // SETTLE cycles, converts, and either reports or times out; the irq lands
  // in the SELECT cycle that finds nothing left. Returns that irq cycle.
  function automatic int plan_sweep(input int n, input logic [7:0] mask);
    int t;
    int s;
    t = n + 1;
    for (int c = 0; c < 8; c++) begin
      if (mask[c]) begin
        s = t + 1 + SETTLE;
        for (int k = t + 1; k <= s; k++) exp_amux[k] = 3'(c);
        exp_start[s] = 1'b1;
        if (dead_mask[c]) begin
          t = s + 1 + TMO;
        end else begin
          exp_res[s + LAT + 1] = (c << 16) | (12'h100 + c);
          t = s + LAT + 2;
        end
      end
    end
    for (int k = n + 1; k <= t; k++) exp_busy[k] = 1'b1;
    exp_irq[t] = 1'b1;
    return t;
  endfunction

  // ADC model: answers LAT cycles after each start unless the channel is dead.
  initial begin
    adc_done = 1'b0;
    adc_data = '0;
    forever begin
      @(negedge PCLK);
      if (cyc == resp_due) begin
        adc_done = 1'b1;
        adc_data = 12'h100 + 12'(resp_ch);
      end else begin
        adc_done = 1'b0;
        adc_data = '0;
      end
      if (adc_start && !dead_mask[adc_amux]) begin
        resp_due = cyc + LAT;
        resp_ch  = adc_amux;
      end
    end
  end

  // Per-cycle compare against the schedule.
  initial begin
    forever begin
      @(negedge PCLK);
      if (chk_on) begin
        chk("start", 32'(adc_start), 32'(exp_start.exists(cyc)));
        chk("valid", 32'(res_valid), 32'(exp_res.exists(cyc)));
        chk("irq",   32'(seq_done_irq), 32'(exp_irq.exists(cyc)));
        chk("busy",  32'(seq_busy), 32'(exp_busy.exists(cyc)));
        if (exp_res.exists(cyc)) begin
          chk("res_ch",   32'(res_ch), 32'(exp_res[cyc] >> 16));
          chk("res_data", 32'(res_data), 32'(exp_res[cyc] & 32'hFFF));
        end
        if (exp_amux.exists(cyc)) chk("amux", 32'(adc_amux), 32'(exp_amux[cyc]));
      end
    end
  end

  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge PCLK);
  endtask

  task automatic pulse_trig();
    sw_trigger = 1'b1;
    @(negedge PCLK);
    sw_trigger = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge PCLK);
    err_clr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    int t;
    int t2;
    int p;
    PRESETn     = 1'b0;
    cfg_enable  = 1'b0;
    cfg_ch_mask = '0;
    cfg_period  = '0;
    sw_trigger  = 1'b0;
    err_clr     = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("rst_start", 32'(adc_start), 0);
    chk("rst_busy",  32'(seq_busy), 0);
    chk("rst_amux",  32'(adc_amux), 0);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_irq",   32'(seq_done_irq), 0);
    chk("rst_to",    32'(timeout_err), 0);
    chk("rst_ov",    32'(overrun_err), 0);
    PRESETn    = 1'b1;
    cfg_enable = 1'b1;
    @(negedge PCLK);
    chk_on = 1'b1;
    repeat (3) @(negedge PCLK);

    // Single sweep over channels 2, 5, 7.
    cfg_ch_mask = 8'b1010_0100;
    n = cyc;
    t = plan_sweep(n, cfg_ch_mask);
    chk("model_sweep_len", 32'(t - n), 73);
    chk("model_first_start", 32'(exp_start.exists(n + 18)), 1);
    pulse_trig();
    wait_cyc(n + 24);
    chk("s1_res2_valid", 32'(res_valid), 1);
    chk("s1_res2_data",  32'(res_data), 32'h102);
    wait_cyc(n + 72);
    chk("s1_res7_data",  32'(res_data), 32'h107);
    wait_cyc(t + 3);

    // Timeout on channel 3.
    dead_mask   = 8'h08;
    cfg_ch_mask = 8'h0F;
    n = cyc;
    t = plan_sweep(n, cfg_ch_mask);
    chk("model_to_len", 32'(t - n), 1114);
    pulse_trig();
    wait_cyc(n + 1113);
    chk("to_before", 32'(timeout_err), 0);
    wait_cyc(n + 1114);
    chk("to_set", 32'(timeout_err), 1);
    wait_cyc(t + 2);
    dead_mask = 8'h00;
    chk("to_sticky", 32'(timeout_err), 1);
    pulse_clr();
    chk("to_clr", 32'(timeout_err), 0);
    repeat (2) @(negedge PCLK);

    // Overrun, one pending sweep, and mask change mid-sweep.
    cfg_ch_mask = 8'h03;
    n = cyc;
    t = plan_sweep(n, cfg_ch_mask);
    chk("model_ov_len", 32'(t - n), 49);
    pulse_trig();
    wait_cyc(n + 10);
    pulse_trig();
    wait_cyc(n + 20);
    chk("ov_before", 32'(overrun_err), 0);
    pulse_trig();
    chk("ov_set", 32'(overrun_err), 1);
    wait_cyc(n + 30);
    cfg_ch_mask = 8'h04;
    t2 = plan_sweep(t + 1, 8'h04);
    chk("model_pending_len", 32'(t2 - t), 26);
    wait_cyc(t2 + 30);
    chk("ov_sticky", 32'(overrun_err), 1);
    pulse_clr();
    chk("ov_clr", 32'(overrun_err), 0);

    // Empty mask.
    cfg_ch_mask = 8'h00;
    n = cyc;
    t = plan_sweep(n, cfg_ch_mask);
    chk("model_empty_len", 32'(t - n), 1);
    pulse_trig();
    chk("empty_irq", 32'(seq_done_irq), 1);
    wait_cyc(n + 4);

    // Abort in SETTLE.
    cfg_ch_mask = 8'h10;
    n = cyc;
    for (int k = n + 1; k <= n + 5; k++) exp_busy[k] = 1'b1;
    for (int k = n + 2; k <= n + 5; k++) exp_amux[k] = 3'd4;
    pulse_trig();
    wait_cyc(n + 5);
    cfg_enable = 1'b0;
    @(negedge PCLK);
    chk("abort_idle", 32'(seq_busy), 0);
    cfg_enable = 1'b1;
    wait_cyc(n + 40);
    chk("abort_amux_kept", 32'(adc_amux), 4);

    // Periodic sweeps, then periodic mode off.
    cfg_ch_mask = 8'h01;
    p = cyc;
    cfg_period = 16'd200;
    t = plan_sweep(p + 200, 8'h01);
    t = plan_sweep(p + 400, 8'h01);
    t = plan_sweep(p + 600, 8'h01);
    wait_cyc(p + 418);
    chk("per_start2", 32'(adc_start), 1);
    wait_cyc(p + 650);
    cfg_period = 16'd0;
    wait_cyc(p + 1000);

    // Reset during WAIT_DONE.
    n = cyc;
    t = plan_sweep(n, cfg_ch_mask);
    pulse_trig();
    wait_cyc(n + 20);
    chk("pre_rst_busy", 32'(seq_busy), 1);
    chk_on  = 1'b0;
    PRESETn = 1'b0;
    #1;
    chk("mid_rst_busy",  32'(seq_busy), 0);
    chk("mid_rst_amux",  32'(adc_amux), 0);
    chk("mid_rst_start", 32'(adc_start), 0);
    chk("mid_rst_valid", 32'(res_valid), 0);
    chk("mid_rst_data",  32'(res_data), 0);
    exp_start.delete();
    exp_irq.delete();
    exp_busy.delete();
    exp_res.delete();
    exp_amux.delete();
    resp_due = -1;
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    chk_on  = 1'b1;
    repeat (40) @(negedge PCLK);
    chk("post_rst_busy", 32'(seq_busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
